// File: rtl/stepper_axis_controller.sv
// Per-axis STEP/DIR pulse generator with direction setup delay,
// clamped step period, abort and an idle-level done flag.
module stepper_axis_controller #(
    parameter int STEPS_W     = 16,
    parameter int PERIOD_W    = 16,
    parameter int PULSE_WIDTH = 50,
    parameter int DIR_SETUP   = 10
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_Start,
    input  logic                i_Dir,
    input  logic [STEPS_W-1:0]  i_Steps,
    input  logic [PERIOD_W-1:0] i_Period,
    input  logic                i_Abort,
    output logic                o_Step,
    output logic                o_Dir,
    output logic                o_Busy,
    output logic                o_Done,
    output logic [STEPS_W-1:0]  o_StepsRemaining
);

    localparam int PW_W   = $clog2(PULSE_WIDTH + 2);
    localparam int DS_W   = $clog2(DIR_SETUP + 1);
    localparam int CNT_W0 = (PERIOD_W > PW_W) ? PERIOD_W : PW_W;
    localparam int CNT_W  = (CNT_W0 > DS_W) ? CNT_W0 : DS_W;

    typedef enum logic [1:0] {
        IDLE,
        DIR_WAIT,
        STEP_HIGH,
        STEP_LOW
    } axisState_t;

    axisState_t         state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [CNT_W-1:0]   lowTime, lowTimeNext;
    logic [STEPS_W-1:0] remaining, remainingNext;
    logic               stepReg, stepNext;
    logic               dirReg, dirNext;
    logic               busyReg, busyNext;
    logic               doneReg, doneNext;
    logic [31:0]        periodExt, lowCalc;

    // Low time is Peff-PULSE_WIDTH with Peff clamped to at least PULSE_WIDTH+1.
    always_comb begin
        periodExt = 32'(i_Period);
        lowCalc   = (periodExt > 32'(PULSE_WIDTH))
                  ? periodExt - 32'(PULSE_WIDTH) : 32'd1;
    end

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        lowTimeNext   = lowTime;
        remainingNext = remaining;
        stepNext      = stepReg;
        dirNext       = dirReg;
        busyNext      = busyReg;
        unique case (state)
            IDLE: begin
                if (i_Start && !i_Abort && (i_Steps != '0)) begin
                    stateNext     = DIR_WAIT;
                    cntNext       = CNT_W'(DIR_SETUP - 1);
                    lowTimeNext   = CNT_W'(lowCalc);
                    dirNext       = i_Dir;
                    remainingNext = i_Steps;
                    busyNext      = 1'b1;
                end
            end
            DIR_WAIT, STEP_LOW: begin
                if (cnt == '0) begin
                    stateNext     = STEP_HIGH;
                    stepNext      = 1'b1;
                    remainingNext = remaining - 1'b1;
                    cntNext       = CNT_W'(PULSE_WIDTH - 1);
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            STEP_HIGH: begin
                if (cnt != '0) begin
                    cntNext = cnt - 1'b1;
                end else if (remaining == '0) begin
                    // Last pulse: trailing low time is not waited.
                    stateNext = IDLE;
                    stepNext  = 1'b0;
                    busyNext  = 1'b0;
                end else begin
                    stateNext = STEP_LOW;
                    stepNext  = 1'b0;
                    cntNext   = lowTime - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (i_Abort && (state != IDLE)) begin
            stateNext     = IDLE;
            cntNext       = '0;
            remainingNext = '0;
            stepNext      = 1'b0;
            busyNext      = 1'b0;
        end
        doneNext = ~busyNext;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lowTime   <= '0;
            remaining <= '0;
            stepReg   <= 1'b0;
            dirReg    <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b1;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            lowTime   <= lowTimeNext;
            remaining <= remainingNext;
            stepReg   <= stepNext;
            dirReg    <= dirNext;
            busyReg   <= busyNext;
            doneReg   <= doneNext;
        end
    end

    assign o_Step           = stepReg;
    assign o_Dir            = dirReg;
    assign o_Busy           = busyReg;
    assign o_Done           = doneReg;
    assign o_StepsRemaining = remaining;

endmodule

// File: tb/tb_stepper_axis_controller.sv
// Directed bench for stepper_axis_controller, PULSE_WIDTH=4, DIR_SETUP=2.
// Expected waveforms come from the closed-form move timing.
module tb_stepper_axis_controller;

    localparam int PW = 4;
    localparam int DS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [15:0] steps;
    logic [15:0] period;
    logic        abort;
    logic        step;
    logic        oDir;
    logic        busy;
    logic        done;
    logic [15:0] rem;

    int errors = 0;
    int checks = 0;

    stepper_axis_controller #(
        .STEPS_W(16),
        .PERIOD_W(16),
        .PULSE_WIDTH(PW),
        .DIR_SETUP(DS)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Start(start),
        .i_Dir(dir),
        .i_Steps(steps),
        .i_Period(period),
        .i_Abort(abort),
        .o_Step(step),
        .o_Dir(oDir),
        .o_Busy(busy),
        .o_Done(done),
        .o_StepsRemaining(rem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input int expDir);
        check({tag, ".step"}, int'(step), 0);
        check({tag, ".dir"}, int'(oDir), expDir);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".rem"}, int'(rem), 0);
    endtask

    // Cycle 0 is the cycle i_Start is high; cycle c is sampled just after edge c.
    task automatic runMove(input string tag, input logic d, input int n,
                           input int per, input int injectAt,
                           input int abortAt);
        int   peff, endC, rises, lastC, expBusy, expStep, expRem, k;
        logic prev;
        peff  = (per > PW) ? per : PW + 1;
        endC  = 1 + DS + (n - 1) * peff + PW;
        lastC = (abortAt > 0) ? abortAt : endC + 1;
        dir    = d;
        steps  = 16'(n);
        period = 16'(per);
        start  = 1'b1;
        tick();
        start = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int c = 1; c <= lastC; c++) begin
            expBusy = (c < endC) ? 1 : 0;
            expStep = 0;
            expRem  = n;
            if (c >= 1 + DS) begin
                k = (c - 1 - DS) / peff + 1;
                if (k > n) k = n;
                expRem = n - k;
                if (expBusy == 1 && ((c - 1 - DS) % peff) < PW) expStep = 1;
            end
            check($sformatf("%s.c%0d.step", tag, c), int'(step), expStep);
            check($sformatf("%s.c%0d.done", tag, c), int'(done), 1 - expBusy);
            check($sformatf("%s.c%0d.busy", tag, c), int'(busy), expBusy);
            check($sformatf("%s.c%0d.dir", tag, c), int'(oDir), int'(d));
            check($sformatf("%s.c%0d.rem", tag, c), int'(rem), expRem);
            if (step && !prev) rises++;
            prev = step;
            if (c == injectAt) begin
                start  = 1'b1;
                dir    = ~d;
                steps  = 16'd7;
                period = 16'd2;
            end
            if (c == abortAt) abort = 1'b1;
            tick();
            start = 1'b0;
            abort = 1'b0;
        end
        if (abortAt > 0) checkIdle({tag, ".abort"}, int'(d));
        else check({tag, ".rises"}, rises, n);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        dir    = 1'b0;
        steps  = '0;
        period = '0;
        abort  = 1'b0;
        repeat (3) tick();
        checkIdle("reset", 0);
        rst = 1'b0;
        tick();

        runMove("m3p10", 1'b1, 3, 10, 0, 0);

        runMove("clamp", 1'b0, 2, 2, 0, 0);

        dir   = 1'b1;
        steps = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checkIdle($sformatf("zero.c%0d", c), 0);
            tick();
        end

        runMove("abort", 1'b1, 5, 10, 0, 14);
        runMove("afterAbort", 1'b0, 2, 10, 0, 0);

        dir   = 1'b1;
        steps = 16'd3;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkIdle("abortStart.c1", 0);
        tick();
        checkIdle("abortStart.c2", 0);

        runMove("busyStart", 1'b1, 3, 10, 5, 0);

        dir    = 1'b1;
        steps  = 16'd4;
        period = 16'd10;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("midReset.pre.busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        checkIdle("midReset", 0);
        rst = 1'b0;
        tick();
        checkIdle("midReset.post", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
